chnl_acc: RTL and testbench

Cross-channel accumulator that sits directly downstream of the 3x3 convolution stage. It consumes one signed 8-bit per-channel convolution result per pixel, together with that stage's end-of-channel pulse. It sums results across NCH input channels in an on-chip partial-sum buffer and adds a per-output-channel bias. It then applies ReLU, arithmetic right-shift requantization and saturation, and emits one 8-bit activation per pixel during the last input channel.

---
 rtl/chnl_acc.sv | 173 +++++++++++++++++
 tb/tb_chnl_acc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/chnl_acc.sv
// Cross-channel accumulator: sums signed per-channel conv results over NCH input
// channels in a partial-sum array, adds bias, then ReLU / shift / saturate to 0..127.
module chnl_acc #(
  parameter int NPIX  = 900,
  parameter int NCH   = 3,
  parameter int ACCW  = 20,
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        chnl_done_i,
  input  logic [15:0] bias,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        layer_done,
  output logic        err_o
);

  localparam int PW = $clog2(NPIX + 1);
  localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [PW-1:0]          PIX_END = PW'(NPIX);
  localparam logic [CW-1:0]          CH_LAST = CW'(NCH - 1);
  localparam logic signed [ACCW-1:0] QMAX    = ACCW'(127);

  typedef enum logic [1:0] {
    PH_FIRST,
    PH_MID,
    PH_LAST,
    PH_FIRST_LAST
  } phase_t;

  // Handshake: data_i is consumed on every cycle valid_i is high; there is no
  // ready. valid_o / layer_done are single-cycle pulses with no backpressure.

  logic [PW-1:0]          pix;
  logic [PW-1:0]          pix_next;
  logic [PW-1:0]          pix_after;
  logic [CW-1:0]          ch;
  logic [CW-1:0]          ch_next;
  logic [AW-1:0]          addr;
  phase_t                 phase;

  logic signed [ACCW-1:0] psum [NPIX];
  logic signed [ACCW-1:0] psum_rd;
  logic signed [ACCW-1:0] data_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shifted;
  logic [7:0]             q;

  logic pix_full;
  logic accept;
  logic drop;
  logic psum_we;
  logic out_en;
  logic err_set;
  logic last_done;

  assign addr     = pix[AW-1:0];
  assign pix_full = (pix == PIX_END);
  assign accept   = valid_i && !pix_full;
  assign drop     = valid_i && pix_full;
  assign data_ext = {{(ACCW-8){data_i[7]}}, data_i};
  assign bias_ext = {{(ACCW-16){bias[15]}}, bias};

  // Phase decode: the channel counter is the state register of this FSM.
  always_comb begin
    phase = PH_FIRST;
    if (NCH == 1)
      phase = PH_FIRST_LAST;
    else if (ch == '0)
      phase = PH_FIRST;
    else if (ch == CH_LAST)
      phase = PH_LAST;
    else
      phase = PH_MID;
  end

  // Next-state for both counters plus the protocol error terms.
  always_comb begin
    pix_after = pix + PW'(accept);
    pix_next  = pix_after;
    ch_next   = ch;
    last_done = 1'b0;
    err_set   = drop;
    if (chnl_done_i) begin
      pix_next = '0;
      if (pix_after != PIX_END)
        err_set = 1'b1;
      if (ch == CH_LAST) begin
        ch_next   = '0;
        last_done = 1'b1;
      end else begin
        ch_next = ch + CW'(1);
      end
    end
  end

  // Read is guarded so a full pixel counter never addresses past the array.
  always_comb begin
    psum_rd = '0;
    if (!pix_full)
      psum_rd = psum[addr];
  end

  always_comb begin
    base    = psum_rd;
    psum_we = 1'b0;
    out_en  = 1'b0;
    case (phase)
      PH_FIRST: begin
        base    = bias_ext;
        psum_we = accept;
      end
      PH_MID: begin
        psum_we = accept;
      end
      PH_LAST: begin
        out_en = accept;
      end
      PH_FIRST_LAST: begin
        base   = bias_ext;
        out_en = accept;
      end
      default: begin
        base = psum_rd;
      end
    endcase
    sum = base + data_ext;
  end

  // ReLU, truncating arithmetic shift, clamp to 127.
  always_comb begin
    q       = 8'd0;
    shifted = sum >>> SHIFT;
    if (!sum[ACCW-1] && (sum != '0)) begin
      if (shifted > QMAX)
        q = 8'd127;
      else
        q = shifted[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (psum_we)
      psum[addr] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix        <= '0;
      ch         <= '0;
      data_o     <= 8'd0;
      valid_o    <= 1'b0;
      layer_done <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      pix        <= pix_next;
      ch         <= ch_next;
      valid_o    <= out_en;
      layer_done <= last_done;
      err_o      <= err_o | err_set;
      if (out_en)
        data_o <= q;
    end
  end

endmodule

// File: tb/tb_chnl_acc.sv
// Directed bench for chnl_acc: two instances (SHIFT=2 and SHIFT=0) share one
// stimulus stream; each pixel carries hand-computed expected results for both.
module tb_chnl_acc;

  localparam int NPIX = 4;
  localparam int NCH  = 3;
  localparam int ACCW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        chnl_done_i;
  logic [15:0] bias;
  logic [7:0]  data2, data0;
  logic        valid2, valid0;
  logic        ld2, ld0;
  logic        err2, err0;

  int checks = 0;
  int errors = 0;

  byte vec [3][4];
  int  e2 [4];
  int  e0 [4];

  always #5 clk = ~clk;

  chnl_acc #(.NPIX(NPIX), .NCH(NCH), .ACCW(ACCW), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .chnl_done_i(chnl_done_i), .bias(bias), .data_o(data2),
    .valid_o(valid2), .layer_done(ld2), .err_o(err2)
  );

  chnl_acc #(.NPIX(NPIX), .NCH(NCH), .ACCW(ACCW), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .chnl_done_i(chnl_done_i), .bias(bias), .data_o(data0),
    .valid_o(valid0), .layer_done(ld0), .err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic done);
    valid_i     = v;
    data_i      = d;
    chnl_done_i = done;
    @(posedge clk);
    #1;
    valid_i     = 1'b0;
    chnl_done_i = 1'b0;
  endtask

  // Runs one full layer from vec; same = chnl_done_i rides on pixel 3's valid.
  task automatic run_layer(input int b, input bit same, input logic exp_err);
    bias = 16'(b);
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < NPIX; p++) begin
        cycle(1'b1, vec[c][p], same && (p == NPIX - 1));
        if (c == NCH - 1) begin
          check("valid_o", valid2, 1);
          check("data_o_s2", data2, e2[p]);
          check("data_o_s0", data0, e0[p]);
        end else begin
          check("valid_o_quiet", valid2, 0);
        end
        if (p == NPIX - 1) begin
          if (!same) begin
            cycle(1'b0, 8'd0, 1'b1);
            check("valid_o_gap", valid2, 0);
          end
          check("layer_done", ld2, 32'(c == NCH - 1));
        end
      end
    end
    cycle(1'b0, 8'd0, 1'b0);
    check("layer_done_pulse", ld2, 0);
    check("err_o", err2, exp_err);
    check("err_o_s0", err0, exp_err);
  endtask

  initial begin
    rst         = 1'b1;
    valid_i     = 1'b0;
    chnl_done_i = 1'b0;
    data_i      = 8'd0;
    bias        = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_o", data2, 0);
    check("rst_valid_o", valid2, 0);
    check("rst_layer_done", ld2, 0);
    check("rst_err_o", err2, 0);
    rst = 1'b0;

    // Accumulate, negative clamp, shift truncation
    vec = '{'{1, 0, -128, 127}, '{2, 0, -128, 127}, '{3, 0, -128, 127}};
    e2  = '{4, 2, 0, 97};
    e0  = '{16, 10, 0, 127};
    run_layer(10, 1'b0, 1'b0);

    // ReLU at negative and zero sums; sum of 1 shifts to 0
    vec = '{'{-10, 100, 50, 51}, '{5, 100, 0, 0}, '{5, 100, 0, 0}};
    e2  = '{0, 62, 0, 0};
    e0  = '{0, 127, 0, 1};
    run_layer(-50, 1'b1, 1'b0);

    // Saturation with a large bias
    vec = '{'{127, -128, 0, -100}, '{127, -128, 0, -100}, '{127, -128, 0, -100}};
    e2  = '{127, 127, 127, 127};
    e0  = '{127, 127, 127, 127};
    run_layer(1000, 1'b0, 1'b0);

    // Small bias, 127/128 saturation boundary
    vec = '{'{1, -2, 122, 123}, '{1, -2, 0, 0}, '{1, -2, 0, 0}};
    e2  = '{2, 0, 31, 32};
    e0  = '{8, 0, 127, 127};
    run_layer(5, 1'b1, 1'b0);

    // Same-cycle end of channel with value 7 everywhere
    vec = '{'{7, 7, 7, 7}, '{7, 7, 7, 7}, '{7, 7, 7, 7}};
    e2  = '{5, 5, 5, 5};
    e0  = '{21, 21, 21, 21};
    run_layer(0, 1'b1, 1'b0);

    // Early chnl_done_i: pixel 3 keeps its prior 14 from the layer above
    bias = 16'd0;
    for (int p = 0; p < 3; p++) cycle(1'b1, 8'd10, 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    check("err_early_done", err2, 1);
    check("ld_early_done", ld2, 0);
    for (int p = 0; p < NPIX; p++) begin
      cycle(1'b1, 8'd1, 1'b0);
      check("err_valid_quiet", valid2, 0);
    end
    cycle(1'b0, 8'd0, 1'b1);
    check("err_sticky", err2, 1);
    check("err_ch1_ld", ld2, 0);
    for (int p = 0; p < NPIX; p++) begin
      cycle(1'b1, 8'd1, 1'b0);
      check("err_valid_o", valid2, 1);
      check("err_data_s2", data2, (p == 3) ? 4 : 3);
      check("err_data_s0", data0, (p == 3) ? 16 : 12);
    end
    cycle(1'b1, 8'd50, 1'b0);
    check("overflow_dropped", valid2, 0);
    check("overflow_err", err0, 1);
    cycle(1'b0, 8'd0, 1'b1);
    check("err_layer_done", ld2, 1);
    check("err_still_set", err2, 1);

    // Reset during ch=1 of a partial layer
    for (int p = 0; p < NPIX; p++) cycle(1'b1, 8'd50, 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b1, 8'd50, 1'b0);
    cycle(1'b1, 8'd50, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 8'd50, 1'b0);
    rst = 1'b0;
    check("mid_rst_err", err2, 0);
    check("mid_rst_valid", valid2, 0);
    check("mid_rst_data", data2, 0);
    check("mid_rst_ld", ld2, 0);

    vec = '{'{2, 2, 2, 2}, '{3, 3, 3, 3}, '{4, 4, 4, 4}};
    e2  = '{2, 2, 2, 2};
    e0  = '{9, 9, 9, 9};
    run_layer(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
